interposer_slot_scheduler: RTL and testbench

- Slot-based scheduler for the unidirectional multipoint interposer bus. Data flows from lower to higher node index only.
- Collects per-node transfer requests (valid/dest, held until ack) and packs them into one bus slot of non-overlapping segments, using rotating-priority greedy allocation.
- Drives per-node send/receive/bypass control for a fixed slot length, then acknowledges the served requesters.
- Sits between node request logic and the interposer switch control inputs.

---
 rtl/interposer_slot_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 tb/tb_interposer_slot_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interposer_slot_scheduler.sv
// -----------------------------------------------------------------------------
// interposer_slot_scheduler
//
// Packs per-node transfer requests on the unidirectional (low -> high index)
// multipoint interposer bus into bus slots made of non-overlapping segments.
// Each round scans every node once, starting at a rotating priority pointer,
// and greedily grants any request whose links are still free. The granted
// configuration is then held on the switch controls for SLOT_CYCLES cycles
// and the served requesters are acknowledged in the first held cycle.
// Backward or self transfers are acknowledged with an error in the scan cycle
// of the requesting node and are dropped.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   sched_en     allows new slots to start (looked at in IDLE only)
//   req_valid    per-node request, held by the source until req_ack
//   req_dest     per-node destination, node i at [i*DEST_W +: DEST_W]
//   req_ack      one-cycle pulse, request consumed
//   req_err      one-cycle pulse with req_ack, request was illegal
//   control_port {send, receive, bypass}, NODE_COUNT bits each
//   slot_active  high while control_port carries a live configuration
//
// All outputs are registered. The evaluation of a node is folded into the
// clock edge that opens its scan cycle, so an error pulse and the updated
// link occupancy are visible during the scan cycle of that node, and the
// grant pulse and configuration appear together in the first DRIVE cycle.
// -----------------------------------------------------------------------------
module interposer_slot_scheduler #(
    parameter int NODE_COUNT  = 8,
    parameter int DEST_W      = 3,
    parameter int SLOT_CYCLES = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sched_en,
    input  logic [NODE_COUNT-1:0]        req_valid,
    input  logic [NODE_COUNT*DEST_W-1:0] req_dest,
    output logic [NODE_COUNT-1:0]        req_ack,
    output logic [NODE_COUNT-1:0]        req_err,
    output logic [3*NODE_COUNT-1:0]      control_port,
    output logic                         slot_active
);

    localparam int LINK_COUNT = NODE_COUNT - 1;
    localparam int HOLD_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        EV_NONE  = 2'd0,
        EV_ERR   = 2'd1,
        EV_SKIP  = 2'd2,
        EV_GRANT = 2'd3
    } eval_kind_t;

    // Registered state
    state_t                  state_r;
    logic [DEST_W-1:0]       scan_idx_r;
    logic [DEST_W-1:0]       scan_cnt_r;
    logic [HOLD_W-1:0]       hold_cnt_r;
    logic [DEST_W-1:0]       prio_ptr_r;
    logic [LINK_COUNT-1:0]   link_busy_r;
    logic [NODE_COUNT-1:0]   send_r;
    logic [NODE_COUNT-1:0]   recv_r;
    logic [NODE_COUNT-1:0]   byp_r;
    logic [NODE_COUNT-1:0]   gnt_r;
    logic [NODE_COUNT-1:0]   req_ack_r;
    logic [NODE_COUNT-1:0]   req_err_r;
    logic [3*NODE_COUNT-1:0] control_port_r;
    logic                    slot_active_r;

    // Next-state values
    state_t                  state_s;
    logic [DEST_W-1:0]       scan_idx_s;
    logic [DEST_W-1:0]       scan_cnt_s;
    logic [HOLD_W-1:0]       hold_cnt_s;
    logic [DEST_W-1:0]       prio_ptr_s;
    logic [LINK_COUNT-1:0]   link_busy_s;
    logic [NODE_COUNT-1:0]   send_s;
    logic [NODE_COUNT-1:0]   recv_s;
    logic [NODE_COUNT-1:0]   byp_s;
    logic [NODE_COUNT-1:0]   gnt_s;
    logic [NODE_COUNT-1:0]   req_ack_s;
    logic [NODE_COUNT-1:0]   req_err_s;
    logic [3*NODE_COUNT-1:0] control_port_s;
    logic                    slot_active_s;

    // Node evaluation signals
    logic [DEST_W-1:0]       eval_idx_s;
    logic [LINK_COUNT-1:0]   eval_busy_in_s;
    logic [DEST_W-1:0]       eval_dest_s;
    logic                    eval_valid_s;
    logic [LINK_COUNT-1:0]   seg_links_s;
    logic [NODE_COUNT-1:0]   seg_byp_s;
    eval_kind_t              eval_kind_s;
    logic [NODE_COUNT-1:0]   eval_send_s;
    logic [NODE_COUNT-1:0]   eval_recv_s;
    logic [NODE_COUNT-1:0]   eval_byp_s;
    logic [LINK_COUNT-1:0]   eval_link_s;
    logic [NODE_COUNT-1:0]   eval_gnt_s;
    logic [NODE_COUNT-1:0]   eval_err_s;

    // Pick which node the next edge evaluates and the link occupancy it sees:
    // the priority node on a fresh round, otherwise the next node in order.
    always_comb begin
        eval_idx_s     = prio_ptr_r;
        eval_busy_in_s = {LINK_COUNT{1'b0}};
        case (state_r)
            ST_IDLE: begin
                eval_idx_s     = prio_ptr_r;
                eval_busy_in_s = {LINK_COUNT{1'b0}};
            end
            ST_SCAN: begin
                // wraps naturally because NODE_COUNT is a power of two
                eval_idx_s     = scan_idx_r + DEST_W'(1);
                eval_busy_in_s = link_busy_r;
            end
            default: begin
                eval_idx_s     = prio_ptr_r;
                eval_busy_in_s = {LINK_COUNT{1'b0}};
            end
        endcase
    end

    // Classify one request and build the segment it would occupy.
    always_comb begin
        eval_dest_s  = req_dest[int'(eval_idx_s)*DEST_W +: DEST_W];
        eval_valid_s = req_valid[eval_idx_s];
        seg_links_s  = {LINK_COUNT{1'b0}};
        seg_byp_s    = {NODE_COUNT{1'b0}};
        eval_send_s  = {NODE_COUNT{1'b0}};
        eval_recv_s  = {NODE_COUNT{1'b0}};
        eval_byp_s   = {NODE_COUNT{1'b0}};
        eval_link_s  = {LINK_COUNT{1'b0}};
        eval_gnt_s   = {NODE_COUNT{1'b0}};
        eval_err_s   = {NODE_COUNT{1'b0}};
        eval_kind_s  = EV_NONE;

        // links src .. dest-1 carry the segment
        for (int k = 0; k < LINK_COUNT; k++) begin
            if ((k >= int'(eval_idx_s)) && (k < int'(eval_dest_s))) begin
                seg_links_s[k] = 1'b1;
            end else begin
                seg_links_s[k] = 1'b0;
            end
        end
        // nodes strictly between src and dest only pass the data through
        for (int k = 0; k < NODE_COUNT; k++) begin
            if ((k > int'(eval_idx_s)) && (k < int'(eval_dest_s))) begin
                seg_byp_s[k] = 1'b1;
            end else begin
                seg_byp_s[k] = 1'b0;
            end
        end

        if (eval_valid_s == 1'b0) begin
            eval_kind_s = EV_NONE;
        end else if (eval_dest_s <= eval_idx_s) begin
            eval_kind_s = EV_ERR;
        end else if ((seg_links_s & eval_busy_in_s) != {LINK_COUNT{1'b0}}) begin
            eval_kind_s = EV_SKIP;
        end else begin
            eval_kind_s = EV_GRANT;
        end

        case (eval_kind_s)
            EV_ERR: begin
                eval_err_s[eval_idx_s] = 1'b1;
            end
            EV_GRANT: begin
                eval_send_s[eval_idx_s] = 1'b1;
                eval_recv_s[eval_dest_s] = 1'b1;
                eval_byp_s  = seg_byp_s;
                eval_link_s = seg_links_s;
                eval_gnt_s[eval_idx_s] = 1'b1;
            end
            default: begin
                eval_err_s = {NODE_COUNT{1'b0}};
            end
        endcase
    end

    // Scheduler next-state and registered-output values.
    always_comb begin
        state_s        = state_r;
        scan_idx_s     = scan_idx_r;
        scan_cnt_s     = scan_cnt_r;
        hold_cnt_s     = hold_cnt_r;
        prio_ptr_s     = prio_ptr_r;
        link_busy_s    = link_busy_r;
        send_s         = send_r;
        recv_s         = recv_r;
        byp_s          = byp_r;
        gnt_s          = gnt_r;
        req_ack_s      = {NODE_COUNT{1'b0}};
        req_err_s      = {NODE_COUNT{1'b0}};
        control_port_s = {(3*NODE_COUNT){1'b0}};
        slot_active_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (sched_en && (req_valid != {NODE_COUNT{1'b0}})) begin
                    // the priority node is evaluated on the way into SCAN
                    state_s     = ST_SCAN;
                    scan_idx_s  = prio_ptr_r;
                    scan_cnt_s  = {DEST_W{1'b0}};
                    link_busy_s = eval_link_s;
                    send_s      = eval_send_s;
                    recv_s      = eval_recv_s;
                    byp_s       = eval_byp_s;
                    gnt_s       = eval_gnt_s;
                    req_ack_s   = eval_err_s;
                    req_err_s   = eval_err_s;
                end else begin
                    state_s     = ST_IDLE;
                    link_busy_s = {LINK_COUNT{1'b0}};
                    send_s      = {NODE_COUNT{1'b0}};
                    recv_s      = {NODE_COUNT{1'b0}};
                    byp_s       = {NODE_COUNT{1'b0}};
                    gnt_s       = {NODE_COUNT{1'b0}};
                end
            end
            ST_SCAN: begin
                if (scan_cnt_r == DEST_W'(NODE_COUNT - 1)) begin
                    if (gnt_r != {NODE_COUNT{1'b0}}) begin
                        state_s        = ST_DRIVE;
                        hold_cnt_s     = HOLD_W'(SLOT_CYCLES - 1);
                        control_port_s = {send_r, recv_r, byp_r};
                        slot_active_s  = 1'b1;
                        req_ack_s      = gnt_r;
                    end else begin
                        state_s    = ST_IDLE;
                        prio_ptr_s = prio_ptr_r + DEST_W'(1);
                    end
                end else begin
                    scan_idx_s  = eval_idx_s;
                    scan_cnt_s  = scan_cnt_r + DEST_W'(1);
                    link_busy_s = link_busy_r | eval_link_s;
                    send_s      = send_r | eval_send_s;
                    recv_s      = recv_r | eval_recv_s;
                    byp_s       = byp_r | eval_byp_s;
                    gnt_s       = gnt_r | eval_gnt_s;
                    req_ack_s   = eval_err_s;
                    req_err_s   = eval_err_s;
                end
            end
            ST_DRIVE: begin
                if (hold_cnt_r == {HOLD_W{1'b0}}) begin
                    state_s     = ST_IDLE;
                    prio_ptr_s  = prio_ptr_r + DEST_W'(1);
                    link_busy_s = {LINK_COUNT{1'b0}};
                    send_s      = {NODE_COUNT{1'b0}};
                    recv_s      = {NODE_COUNT{1'b0}};
                    byp_s       = {NODE_COUNT{1'b0}};
                    gnt_s       = {NODE_COUNT{1'b0}};
                end else begin
                    hold_cnt_s     = hold_cnt_r - HOLD_W'(1);
                    control_port_s = control_port_r;
                    slot_active_s  = 1'b1;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r        <= ST_IDLE;
            scan_idx_r     <= {DEST_W{1'b0}};
            scan_cnt_r     <= {DEST_W{1'b0}};
            hold_cnt_r     <= {HOLD_W{1'b0}};
            prio_ptr_r     <= {DEST_W{1'b0}};
            link_busy_r    <= {LINK_COUNT{1'b0}};
            send_r         <= {NODE_COUNT{1'b0}};
            recv_r         <= {NODE_COUNT{1'b0}};
            byp_r          <= {NODE_COUNT{1'b0}};
            gnt_r          <= {NODE_COUNT{1'b0}};
            req_ack_r      <= {NODE_COUNT{1'b0}};
            req_err_r      <= {NODE_COUNT{1'b0}};
            control_port_r <= {(3*NODE_COUNT){1'b0}};
            slot_active_r  <= 1'b0;
        end else begin
            state_r        <= state_s;
            scan_idx_r     <= scan_idx_s;
            scan_cnt_r     <= scan_cnt_s;
            hold_cnt_r     <= hold_cnt_s;
            prio_ptr_r     <= prio_ptr_s;
            link_busy_r    <= link_busy_s;
            send_r         <= send_s;
            recv_r         <= recv_s;
            byp_r          <= byp_s;
            gnt_r          <= gnt_s;
            req_ack_r      <= req_ack_s;
            req_err_r      <= req_err_s;
            control_port_r <= control_port_s;
            slot_active_r  <= slot_active_s;
        end
    end

    assign req_ack      = req_ack_r;
    assign req_err      = req_err_r;
    assign control_port = control_port_r;
    assign slot_active  = slot_active_r;

endmodule

// File: tb/tb_interposer_slot_scheduler.sv
// -----------------------------------------------------------------------------
// tb_interposer_slot_scheduler
//
// Self-checking bench for interposer_slot_scheduler. A behavioural model
// packs one round from the request set with segment bit masks, and each
// scenario task walks the round cycle by cycle comparing acks, errors and
// switch controls. Request sources drop a request after seeing its ack.
// -----------------------------------------------------------------------------
module tb_interposer_slot_scheduler;

    localparam int N  = 8;
    localparam int DW = 3;
    localparam int SC = 4;

    logic            clk;
    logic            reset;
    logic            sched_en;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_dest;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    req_err;
    logic [3*N-1:0]  control_port;
    logic            slot_active;

    int           errors;
    int           checks;
    int           exp_ptr;
    bit           hold_static;
    logic [N-1:0] obs_send;
    logic [N-1:0] obs_recv;
    logic [N-1:0] obs_byp;
    logic [N-1:0] seen_err;

    interposer_slot_scheduler #(
        .NODE_COUNT (N),
        .DEST_W     (DW),
        .SLOT_CYCLES(SC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sched_en    (sched_en),
        .req_valid   (req_valid),
        .req_dest    (req_dest),
        .req_ack     (req_ack),
        .req_err     (req_err),
        .control_port(control_port),
        .slot_active (slot_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one round of greedy packing, links as integer bit masks.
    function automatic void model_slot(input int ptr, input logic [N-1:0] v,
                                       input logic [N*DW-1:0] dst,
                                       output logic [N-1:0] send, output logic [N-1:0] recv,
                                       output logic [N-1:0] byp, output logic [N-1:0] gnt,
                                       output logic [N-1:0] step_err);
        int busy;
        int seg;
        int i;
        int d;
        busy = 0;
        send = '0; recv = '0; byp = '0; gnt = '0; step_err = '0;
        for (int j = 0; j < N; j++) begin
            i = (ptr + j) % N;
            d = int'(dst[i*DW +: DW]);
            if (v[i]) begin
                if (d <= i) begin
                    step_err[j] = 1'b1;
                end else begin
                    seg = ((1 << d) - 1) & ~((1 << i) - 1);
                    if ((busy & seg) == 0) begin
                        busy    = busy | seg;
                        send[i] = 1'b1;
                        recv[d] = 1'b1;
                        byp     = byp | 8'(seg & ~(1 << i));
                        gnt[i]  = 1'b1;
                    end
                end
            end
        end
    endfunction

    // Advance one cycle; sources drop requests acknowledged in the cycle left.
    task automatic tick();
        logic [N-1:0] drop;
        drop = hold_static ? 8'h00 : req_ack;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~drop;
    endtask

    task automatic set_req(input int node, input int dest);
        req_valid[node] = 1'b1;
        req_dest[node*DW +: DW] = DW'(dest);
    endtask

    // One full round starting in an IDLE cycle with sched_en high.
    task automatic run_round(input bit add_rand, input bit drop_en, input string tag);
        logic [N-1:0] es, er, eb, eg, estep, exp_mask;
        int node;
        if (add_rand) begin
            for (int n = 0; n < N; n++) begin
                if (!req_valid[n] && ($urandom_range(0, 1) == 1)) begin
                    set_req(n, int'($urandom_range(0, N - 1)));
                end
            end
            if (req_valid == '0) set_req(0, int'($urandom_range(1, N - 1)));
        end
        seen_err = '0;
        obs_send = '0; obs_recv = '0; obs_byp = '0;
        model_slot(exp_ptr, req_valid, req_dest, es, er, eb, eg, estep);
        for (int j = 0; j < N; j++) begin
            tick();
            node = (exp_ptr + j) % N;
            exp_mask = estep[j] ? (8'h01 << node) : 8'h00;
            checks++;
            if (req_ack !== exp_mask) begin
                errors++;
                $display("FAIL %s scan_ack step %0d: got %h expected %h", tag, j, req_ack, exp_mask);
            end
            checks++;
            if (req_err !== exp_mask) begin
                errors++;
                $display("FAIL %s scan_err step %0d: got %h expected %h", tag, j, req_err, exp_mask);
            end
            checks++;
            if (slot_active !== 1'b0 || control_port !== '0) begin
                errors++;
                $display("FAIL %s scan_idle_ctrl step %0d: got %b/%h expected 0/0", tag, j, slot_active, control_port);
            end
            seen_err = seen_err | req_err;
        end
        if (eg != '0) begin
            for (int h = 0; h < SC; h++) begin
                tick();
                if (h == 0 && drop_en) sched_en = 1'b0;
                if (h == 0) begin
                    obs_send = control_port[3*N-1:2*N];
                    obs_recv = control_port[2*N-1:N];
                    obs_byp  = control_port[N-1:0];
                end
                checks++;
                if (control_port !== {es, er, eb}) begin
                    errors++;
                    $display("FAIL %s drive_ctrl cycle %0d: got %h expected %h", tag, h, control_port, {es, er, eb});
                end
                checks++;
                if (slot_active !== 1'b1) begin
                    errors++;
                    $display("FAIL %s drive_active cycle %0d: got %b expected 1", tag, h, slot_active);
                end
                checks++;
                if (req_ack !== ((h == 0) ? eg : 8'h00) || req_err !== 8'h00) begin
                    errors++;
                    $display("FAIL %s drive_ack cycle %0d: got %h/%h expected %h/00", tag, h, req_ack, req_err,
                             (h == 0) ? eg : 8'h00);
                end
            end
        end
        tick();
        exp_ptr = (exp_ptr + 1) % N;
        checks++;
        if (slot_active !== 1'b0 || control_port !== '0 || req_ack !== '0 || req_err !== '0) begin
            errors++;
            $display("FAIL %s end_idle: got %b/%h/%h/%h expected all 0", tag, slot_active, control_port, req_ack, req_err);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        req_valid = '0;
        tick();
        tick();
        exp_ptr = 0;
        checks++;
        if (slot_active !== 1'b0 || control_port !== '0 || req_ack !== '0 || req_err !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %b/%h/%h/%h expected all 0", slot_active, control_port, req_ack, req_err);
        end
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        sched_en = 1'b1;
        tick();
        checks++;
        if (slot_active !== 1'b0 || req_ack !== '0) begin
            errors++;
            $display("FAIL reset_idle: got %b/%h expected 0/00", slot_active, req_ack);
        end
    endtask

    task automatic test_basic_pack();
        set_req(0, 3); set_req(2, 5); set_req(3, 6);
        run_round(1'b0, 1'b0, "pack1");
        checks++;
        if (obs_send !== 8'h09 || obs_recv !== 8'h48 || obs_byp !== 8'h36) begin
            errors++;
            $display("FAIL pack1_cfg: got %h/%h/%h expected 09/48/36", obs_send, obs_recv, obs_byp);
        end
        checks++;
        if (req_valid !== 8'h04) begin
            errors++;
            $display("FAIL pack1_pending: got %h expected 04", req_valid);
        end
        run_round(1'b0, 1'b0, "pack2");
        checks++;
        if (obs_send !== 8'h04 || obs_recv !== 8'h20 || obs_byp !== 8'h18) begin
            errors++;
            $display("FAIL pack2_cfg: got %h/%h/%h expected 04/20/18", obs_send, obs_recv, obs_byp);
        end
    endtask

    task automatic test_backward_err();
        set_req(5, 2);
        run_round(1'b0, 1'b0, "err");
        checks++;
        if (seen_err !== 8'h20 || req_valid !== 8'h00) begin
            errors++;
            $display("FAIL err_node5: got err %h valid %h expected 20/00", seen_err, req_valid);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        set_req(0, 0);
        run_round(1'b0, 1'b0, "prio_adv");
        set_req(1, 7); set_req(0, 2);
        run_round(1'b0, 1'b0, "prio1");
        checks++;
        if (obs_send !== 8'h02 || obs_recv !== 8'h80 || obs_byp !== 8'h7C || req_valid !== 8'h01) begin
            errors++;
            $display("FAIL prio1_cfg: got %h/%h/%h valid %h expected 02/80/7c valid 01",
                     obs_send, obs_recv, obs_byp, req_valid);
        end
        run_round(1'b0, 1'b0, "prio2");
        checks++;
        if (obs_send !== 8'h01 || obs_recv !== 8'h04 || obs_byp !== 8'h02) begin
            errors++;
            $display("FAIL prio2_cfg: got %h/%h/%h expected 01/04/02", obs_send, obs_recv, obs_byp);
        end
    endtask

    task automatic test_reset_mid_drive();
        apply_reset();
        hold_static = 1'b1;
        set_req(0, 2); set_req(1, 7);
        for (int j = 0; j < N; j++) tick();
        tick();
        checks++;
        if (req_ack !== 8'h01 || slot_active !== 1'b1) begin
            errors++;
            $display("FAIL rst_drive1: got ack %h active %b expected 01/1", req_ack, slot_active);
        end
        tick();
        checks++;
        if (slot_active !== 1'b1 || req_ack !== 8'h00) begin
            errors++;
            $display("FAIL rst_drive2: got active %b ack %h expected 1/00", slot_active, req_ack);
        end
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (slot_active !== 1'b0 || control_port !== '0 || req_ack !== '0 || req_err !== '0) begin
                errors++;
                $display("FAIL rst_abort cycle %0d: got %b/%h/%h/%h expected all 0",
                         c, slot_active, control_port, req_ack, req_err);
            end
        end
        reset = 1'b1;
        hold_static = 1'b0;
        exp_ptr = 0;
        run_round(1'b0, 1'b0, "rst_reserve1");
        checks++;
        if (obs_send !== 8'h01 || obs_recv !== 8'h04 || obs_byp !== 8'h02) begin
            errors++;
            $display("FAIL rst_reserve1_cfg: got %h/%h/%h expected 01/04/02", obs_send, obs_recv, obs_byp);
        end
        run_round(1'b0, 1'b0, "rst_reserve2");
        checks++;
        if (obs_send !== 8'h02 || obs_recv !== 8'h80 || obs_byp !== 8'h7C) begin
            errors++;
            $display("FAIL rst_reserve2_cfg: got %h/%h/%h expected 02/80/7c", obs_send, obs_recv, obs_byp);
        end
    endtask

    task automatic test_sched_en_gate();
        set_req(0, 2); set_req(1, 7);
        run_round(1'b0, 1'b1, "gate1");
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (slot_active !== 1'b0 || control_port !== '0 || req_ack !== '0) begin
                errors++;
                $display("FAIL gate_hold cycle %0d: got %b/%h/%h expected all 0", c, slot_active, control_port, req_ack);
            end
        end
        checks++;
        if (req_valid !== 8'h02) begin
            errors++;
            $display("FAIL gate_pending: got %h expected 02", req_valid);
        end
        sched_en = 1'b1;
        run_round(1'b0, 1'b0, "gate2");
        checks++;
        if (obs_send !== 8'h02 || obs_recv !== 8'h80 || obs_byp !== 8'h7C) begin
            errors++;
            $display("FAIL gate2_cfg: got %h/%h/%h expected 02/80/7c", obs_send, obs_recv, obs_byp);
        end
    endtask

    task automatic test_random_rounds();
        apply_reset();
        sched_en = 1'b1;
        for (int r = 0; r < 40; r++) run_round(1'b1, 1'b0, "rand");
    endtask

    initial begin
        errors = 0;
        checks = 0;
        exp_ptr = 0;
        hold_static = 1'b0;
        reset = 1'b0;
        sched_en = 1'b0;
        req_valid = '0;
        req_dest = '0;
        test_reset();
        test_basic_pack();
        test_backward_err();
        test_priority();
        test_reset_mid_drive();
        test_sched_en_gate();
        test_random_rounds();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
